gbc_timer: RTL and testbench



---
 rtl/gbc_timer_if.sv | 19 +
 rtl/gbc_timer.sv | 146 ++++++++++++++
 tb/tb_gbc_timer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gbc_timer_if.sv
// IO register bus control for the timer block: address and active-low strobes.
// The shared data bus stays a top-level inout so it can be resolved as a tristate.
interface gbc_timer_if;
    logic [15:0] ioreg_addr;
    logic        ioreg_we_l;
    logic        ioreg_re_l;

    modport master (
        output ioreg_addr,
        output ioreg_we_l,
        output ioreg_re_l
    );

    modport slave (
        input  ioreg_addr,
        input  ioreg_we_l,
        input  ioreg_re_l
    );
endinterface

// File: rtl/gbc_timer.sv
// DIV/TIMA/TMA/TAC divider-timer with delayed TMA reload and one-clock interrupt.
// Optional GBC_TIMER_SPEED_SWITCH_DIV_RESET_EN holds the divider at zero during a speed switch.
module gbc_timer #(
    parameter logic [15:0] P_BASE_ADDR = 16'hFF04,
    parameter int unsigned P_OVF_DELAY = 4
) (
    input  logic        I_CLK,
    input  logic        I_RESET_L,
    gbc_timer_if.slave  ioreg,
    inout  wire  [7:0]  IO_IOREG_DATA,
    input  logic        I_SPEED_SWITCH_BUSY,
    output logic        O_TIMER_INT,
    output logic [7:0]  O_DIV
);

    localparam logic [15:0] ADDR_DIV   = P_BASE_ADDR;
    localparam logic [15:0] ADDR_TIMA  = P_BASE_ADDR + 16'd1;
    localparam logic [15:0] ADDR_TMA   = P_BASE_ADDR + 16'd2;
    localparam logic [15:0] ADDR_TAC   = P_BASE_ADDR + 16'd3;
    localparam logic [3:0]  OVF_RELOAD = 4'(P_OVF_DELAY - 1);

    typedef enum logic {ST_RUN, ST_OVF_DELAY} state_t;

    // Counter tap feeding the TIMA falling-edge detector, gated by the enable bit.
    function automatic logic tick_src(input logic [2:0] tac_val, input logic [15:0] cnt);
        logic sel;
        case (tac_val[1:0])
            2'b00:   sel = cnt[9];
            2'b01:   sel = cnt[3];
            2'b10:   sel = cnt[5];
            default: sel = cnt[7];
        endcase
        return tac_val[2] & sel;
    endfunction

    state_t      state;
    logic [15:0] div_cnt;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic [3:0]  ovf_cnt;
    logic        en_bit;
    logic        en_prev;
    logic        tick;
    logic [7:0]  wdata;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic        hit_div, hit_tima, hit_tma, hit_tac;
    logic        wr_div, wr_tima, wr_tma, wr_tac;

    assign wdata    = IO_IOREG_DATA;
    assign hit_div  = (ioreg.ioreg_addr == ADDR_DIV);
    assign hit_tima = (ioreg.ioreg_addr == ADDR_TIMA);
    assign hit_tma  = (ioreg.ioreg_addr == ADDR_TMA);
    assign hit_tac  = (ioreg.ioreg_addr == ADDR_TAC);
    assign wr_div   = ~ioreg.ioreg_we_l & hit_div;
    assign wr_tima  = ~ioreg.ioreg_we_l & hit_tima;
    assign wr_tma   = ~ioreg.ioreg_we_l & hit_tma;
    assign wr_tac   = ~ioreg.ioreg_we_l & hit_tac;

    assign en_bit = tick_src(tac, div_cnt);
    assign tick   = en_prev & ~en_bit;
    assign O_DIV  = div_cnt[15:8];

`ifndef GBC_TIMER_SPEED_SWITCH_DIV_RESET_EN
    logic unused_busy;
    assign unused_busy = I_SPEED_SWITCH_BUSY;
`endif

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            div_cnt <= 16'h0000;
        end else if (wr_div) begin
            div_cnt <= 16'h0000;
`ifdef GBC_TIMER_SPEED_SWITCH_DIV_RESET_EN
        end else if (I_SPEED_SWITCH_BUSY) begin
            div_cnt <= 16'h0000;
`endif
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    // In OVF_DELAY the reload edge takes priority over a CPU write to TIMA,
    // and a TMA write on that same edge is forwarded straight into TIMA.
    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state       <= ST_RUN;
            tima        <= 8'h00;
            tma         <= 8'h00;
            tac         <= 3'b000;
            ovf_cnt     <= 4'h0;
            en_prev     <= 1'b0;
            O_TIMER_INT <= 1'b0;
        end else begin
            en_prev     <= en_bit;
            O_TIMER_INT <= 1'b0;
            if (wr_tma) tma <= wdata;
            if (wr_tac) tac <= wdata[2:0];
            case (state)
                ST_RUN: begin
                    if (wr_tima) begin
                        tima <= wdata;
                    end else if (tick) begin
                        if (tima == 8'hFF) begin
                            tima    <= 8'h00;
                            ovf_cnt <= OVF_RELOAD;
                            state   <= ST_OVF_DELAY;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
                ST_OVF_DELAY: begin
                    if (ovf_cnt == 4'h0) begin
                        tima        <= wr_tma ? wdata : tma;
                        O_TIMER_INT <= 1'b1;
                        state       <= ST_RUN;
                    end else if (wr_tima) begin
                        tima  <= wdata;
                        state <= ST_RUN;
                    end else begin
                        ovf_cnt <= ovf_cnt - 4'd1;
                        if (tick) tima <= tima + 8'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        rd_data = 8'h00;
        rd_hit  = 1'b0;
        if (!ioreg.ioreg_re_l) begin
            rd_hit = hit_div | hit_tima | hit_tma | hit_tac;
            if (hit_div)  rd_data = div_cnt[15:8];
            if (hit_tima) rd_data = tima;
            if (hit_tma)  rd_data = tma;
            if (hit_tac)  rd_data = {5'b11111, tac};
        end
    end

    assign IO_IOREG_DATA = rd_hit ? rd_data : 8'hzz;

endmodule

// File: tb/tb_gbc_timer.sv
// Directed bench for gbc_timer: divider, tick select, overflow delay/reload,
// register read-back and speed-switch divider behaviour.
module tb_gbc_timer;

    localparam logic [15:0] A_DIV  = 16'hFF04;
    localparam logic [15:0] A_TIMA = 16'hFF05;
    localparam logic [15:0] A_TMA  = 16'hFF06;
    localparam logic [15:0] A_TAC  = 16'hFF07;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic       timer_int;
    logic [7:0] div_out;
    logic [7:0] drv_data;
    logic       drv_en;
    wire  [7:0] ioreg_data;

    int checks = 0;
    int errors = 0;
    int int_cnt = 0;

    gbc_timer_if ioreg_if ();

    assign ioreg_data = drv_en ? drv_data : 8'hzz;

    gbc_timer dut (
        .I_CLK               (clk),
        .I_RESET_L           (rst_n),
        .ioreg               (ioreg_if),
        .IO_IOREG_DATA       (ioreg_data),
        .I_SPEED_SWITCH_BUSY (busy),
        .O_TIMER_INT         (timer_int),
        .O_DIV               (div_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (timer_int) int_cnt++;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write is sampled on the following posedge.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        ioreg_if.ioreg_addr = a;
        drv_data = d;
        drv_en = 1'b1;
        ioreg_if.ioreg_we_l = 1'b0;
        @(negedge clk);
        ioreg_if.ioreg_we_l = 1'b1;
        drv_en = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        ioreg_if.ioreg_addr = a;
        ioreg_if.ioreg_re_l = 1'b0;
        #1;
        d = ioreg_data;
        ioreg_if.ioreg_re_l = 1'b1;
        #1;
    endtask

    initial begin
        logic [7:0] rv;
        int base;
        int bad;
        rst_n = 1'b0;
        busy = 1'b0;
        drv_data = 8'h00;
        drv_en = 1'b0;
        ioreg_if.ioreg_addr = 16'h0000;
        ioreg_if.ioreg_we_l = 1'b1;
        ioreg_if.ioreg_re_l = 1'b1;
        clocks(3);

        check_val("rst_div", div_out, 8'h00);
        check_val("rst_int", timer_int, 1'b0);
        rd(A_TIMA, rv); check_val("rst_tima", rv, 8'h00);
        rd(A_TAC, rv);  check_val("rst_tac", rv, 8'hF8);
        rst_n = 1'b1;

        // Free-running divider
        clocks(512);
        rd(A_DIV, rv);  check_val("div_512", rv, 8'h02);
        rd(A_TIMA, rv); check_val("tima_idle", rv, 8'h00);
        check_val("no_int_idle", int_cnt, 0);

        // Overflow, delay and reload with counter[3] ticks
        wr(A_TAC, 8'h05);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'hFE);
        wr(A_TMA, 8'h40);
        clocks(14); rd(A_TIMA, rv); check_val("tima_pre_tick", rv, 8'hFE);
        clocks(1);  rd(A_TIMA, rv); check_val("tima_ff", rv, 8'hFF);
        clocks(15); rd(A_TIMA, rv); check_val("tima_ff_hold", rv, 8'hFF);
        clocks(1);  rd(A_TIMA, rv); check_val("tima_ovf", rv, 8'h00);
        clocks(3);  rd(A_TIMA, rv); check_val("tima_delay", rv, 8'h00);
        check_val("int_pre_reload", timer_int, 1'b0);
        clocks(1);  rd(A_TIMA, rv); check_val("tima_reload", rv, 8'h40);
        check_val("int_reload", timer_int, 1'b1);
        clocks(1);  check_val("int_one_clk", timer_int, 1'b0);

        // TIMA write during the delay cancels reload and interrupt
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'hFE);
        wr(A_TMA, 8'h55);
        clocks(31); rd(A_TIMA, rv); check_val("tima_ovf2", rv, 8'h00);
        clocks(1);
        base = int_cnt;
        wr(A_TIMA, 8'h10);
        rd(A_TIMA, rv); check_val("tima_cancel", rv, 8'h10);
        clocks(5);  rd(A_TIMA, rv); check_val("tima_no_reload", rv, 8'h10);
        check_val("no_int_cancel", int_cnt, base);

        // DIV write hits counter[3]=1 (write wins); TMA written on the reload edge
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'hFE);
        wr(A_TMA, 8'h40);
        clocks(34);
        wr(A_TMA, 8'h66);
        rd(A_TIMA, rv); check_val("tima_tma_fwd", rv, 8'h66);
        check_val("int_tma_fwd", timer_int, 1'b1);

        // DIV write while counter[7]=1 produces one increment
        wr(A_TAC, 8'h07);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'h20);
        clocks(130); rd(A_TIMA, rv); check_val("tima_bit7_hi", rv, 8'h20);
        wr(A_DIV, 8'h00);
        check_val("div_cleared", div_out, 8'h00);
        rd(A_TIMA, rv); check_val("tima_div_same", rv, 8'h20);
        clocks(1);  rd(A_TIMA, rv); check_val("tima_div_spur", rv, 8'h21);

        // Same with timer disabled: no increment
        wr(A_TAC, 8'h03);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'h30);
        clocks(130);
        wr(A_DIV, 8'h00);
        clocks(2);  rd(A_TIMA, rv); check_val("tima_div_dis", rv, 8'h30);

        // Register read-back and unmapped address
        wr(A_TAC, 8'hFF); rd(A_TAC, rv); check_val("tac_ff", rv, 8'hFF);
        wr(A_TAC, 8'h02); rd(A_TAC, rv); check_val("tac_02", rv, 8'hFA);
        rd(A_TMA, rv); check_val("tma_rd", rv, 8'h66);
        drv_data = 8'hA5;
        drv_en = 1'b1;
        rd(16'hFF08, rv); check_val("ff08_undriven", rv, 8'hA5);
        drv_en = 1'b0;

        // Speed switch
        wr(A_DIV, 8'h00);
        clocks(16'h1234);
        check_val("div_1234", div_out, 8'h12);
        busy = 1'b1;
        bad = 0;
`ifdef GBC_TIMER_SPEED_SWITCH_DIV_RESET_EN
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (div_out != 8'h00) bad++;
        end
        check_val("div_held_busy", bad, 0);
        rd(A_DIV, rv); check_val("div_rd_busy", rv, 8'h00);
        busy = 1'b0;
        clocks(255); check_val("div_post_255", div_out, 8'h00);
        clocks(1);   check_val("div_post_256", div_out, 8'h01);
`else
        clocks(300);
        rd(A_DIV, rv); check_val("div_busy_run", rv, 8'h13);
        busy = 1'b0;
        clocks(256); check_val("div_post_256", div_out, 8'h14);
`endif

        // Reset in the middle of the overflow delay: no interrupt
        wr(A_TAC, 8'h05);
        wr(A_DIV, 8'h00);
        wr(A_TIMA, 8'hFF);
        clocks(17);
        rd(A_TIMA, rv); check_val("tima_ovf3", rv, 8'h00);
        base = int_cnt;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_div", div_out, 8'h00);
        clocks(2);
        rst_n = 1'b1;
        clocks(10);
        check_val("rst_mid_no_int", int_cnt, base);
        rd(A_TAC, rv); check_val("rst_mid_tac", rv, 8'hF8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
